// File: rtl/cdb_arbiter_if.sv
// Packet types and the FU <-> CDB arbiter interface.
// The master side is the execute stage and squash source; the slave side is the arbiter.
package cdb_arbiter_pkg;
  localparam int ROB_TAG_W  = 5;
  localparam int PHYS_TAG_W = 6;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  done;
    logic [ROB_TAG_W-1:0]  rob_tag;
    logic [PHYS_TAG_W-1:0] dest_tag;
    logic [DATA_W-1:0]     result;
  } fu_out_packet_t;

  typedef struct packed {
    logic                  valid;
    logic [ROB_TAG_W-1:0]  rob_tag;
    logic [PHYS_TAG_W-1:0] dest_tag;
    logic [DATA_W-1:0]     value;
  } cdb_packet_t;
endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU = 6
);
  import cdb_arbiter_pkg::*;

  fu_out_packet_t [NUM_FU:0] ex_cdb_packet;
  logic                      squash;
  logic [NUM_FU:0]           ack;
  cdb_packet_t               cdb_packet;

  modport master (
    output ex_cdb_packet,
    output squash,
    input  ack,
    input  cdb_packet
  );

  modport slave (
    input  ex_cdb_packet,
    input  squash,
    output ack,
    output cdb_packet
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin completion arbiter: grants one finished FU per cycle (combinational ack)
// and registers the winner's result as the next common-data-bus broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 6
) (
  input  logic       clock,
  input  logic       reset,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_FU + 1);
  localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_FU);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  cdb_packet_t      cdb_q, cdb_d;

  logic [NUM_FU:0]  req;
  logic [NUM_FU:0]  ack;
  logic             grant;
  logic [PTR_W-1:0] win;
  int               cand;

  // FU0 occupies an unused slot in the packet array and never requests.
  always_comb begin
    req   = '0;
    grant = 1'b0;
    win   = PTR_FIRST;
    cand  = 0;
    for (int i = 1; i <= NUM_FU; i++) begin
      req[i] = bus.ex_cdb_packet[i].done;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      cand = int'(ptr_q) + k;
      if (cand > NUM_FU) begin
        cand = cand - NUM_FU;
      end
      if (!grant && req[PTR_W'(cand)]) begin
        grant = 1'b1;
        win   = PTR_W'(cand);
      end
    end
    if (!reset || bus.squash) begin
      grant = 1'b0;
    end
  end

  always_comb begin
    ack = '0;
    if (grant) begin
      ack[win] = 1'b1;
    end
  end

  assign bus.ack = ack;

  // Winner moves to lowest priority; squash restarts the search at FU1.
  always_comb begin
    ptr_d = ptr_q;
    cdb_d = '0;
    if (bus.squash) begin
      ptr_d = PTR_FIRST;
    end else if (grant) begin
      ptr_d = (win == PTR_LAST) ? PTR_FIRST : win + PTR_W'(1);
      cdb_d = '{valid:    1'b1,
                rob_tag:  bus.ex_cdb_packet[win].rob_tag,
                dest_tag: bus.ex_cdb_packet[win].dest_tag,
                value:    bus.ex_cdb_packet[win].result};
    end
  end

  // Broadcast stage boundary
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= PTR_FIRST;
      cdb_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cdb_q <= cdb_d;
    end
  end

  assign bus.cdb_packet = cdb_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin order, wrap,
// back-to-back grants, squash, FU0 / vanishing requests and mid-stream reset.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_FU = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter_if #(.NUM_FU(NUM_FU)) bus ();

  cdb_arbiter #(.NUM_FU(NUM_FU)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic set_fu(input logic [2:0] i, input logic [4:0] rob,
                        input logic [5:0] dest, input logic [31:0] res);
    bus.ex_cdb_packet[i] = '{done: 1'b1, rob_tag: rob, dest_tag: dest, result: res};
  endtask

  task automatic set_std(input logic [2:0] i);
    set_fu(i, 5'(i), 6'(i) + 6'd8, 32'hA000_0000 + 32'(i));
  endtask

  task automatic drop_fu(input logic [2:0] i);
    bus.ex_cdb_packet[i].done = 1'b0;
  endtask

  function automatic cdb_packet_t mk(input logic [4:0] rob, input logic [5:0] dest,
                                     input logic [31:0] v);
    return '{valid: 1'b1, rob_tag: rob, dest_tag: dest, value: v};
  endfunction

  function automatic cdb_packet_t std_cdb(input logic [2:0] i);
    return mk(5'(i), 6'(i) + 6'd8, 32'hA000_0000 + 32'(i));
  endfunction

  task automatic test_reset();
    bus.squash = 1'b0;
    reset = 1'b0;
    for (int i = 0; i <= NUM_FU; i++) set_std(3'(i));
    for (int n = 0; n < 2; n++) begin
      step();
      #1;
      checks++;
      if (bus.ack !== 7'b0) begin
        errors++; $display("FAIL reset_ack: got %b want %b", bus.ack, 7'b0);
      end
      checks++;
      if (bus.cdb_packet !== cdb_packet_t'(0)) begin
        errors++; $display("FAIL reset_cdb: got %h want 0", bus.cdb_packet);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ack !== 7'b0000010) begin
      errors++; $display("FAIL reset_first_grant: got %b want %b", bus.ack, 7'b0000010);
    end
    step();
    bus.ex_cdb_packet = '0;
    checks++;
    if (bus.cdb_packet !== std_cdb(3'd1)) begin
      errors++; $display("FAIL reset_first_cdb: got %h want %h", bus.cdb_packet, std_cdb(3'd1));
    end
  endtask

  task automatic test_single();
    pulse_reset();
    bus.ex_cdb_packet = '0;
    set_fu(3'd3, 5'd5, 6'd12, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (bus.ack !== 7'b0001000) begin
      errors++; $display("FAIL single_ack: got %b want %b", bus.ack, 7'b0001000);
    end
    step();
    bus.ex_cdb_packet = '0;
    checks++;
    if (bus.cdb_packet !== mk(5'd5, 6'd12, 32'hDEAD_BEEF)) begin
      errors++; $display("FAIL single_cdb: got %h want %h", bus.cdb_packet,
                         mk(5'd5, 6'd12, 32'hDEAD_BEEF));
    end
    #1;
    checks++;
    if (bus.ack !== 7'b0) begin
      errors++; $display("FAIL single_ack_idle: got %b want %b", bus.ack, 7'b0);
    end
    step();
    checks++;
    if (bus.cdb_packet !== cdb_packet_t'(0)) begin
      errors++; $display("FAIL single_cdb_idle: got %h want 0", bus.cdb_packet);
    end
  endtask

  task automatic test_round_robin();
    int order[3] = '{1, 2, 5};
    logic [6:0] want;
    pulse_reset();
    bus.ex_cdb_packet = '0;
    set_std(3'd1); set_std(3'd2); set_std(3'd5);
    for (int n = 0; n < 3; n++) begin
      #1;
      want = 7'd1 << order[n];
      checks++;
      if (bus.ack !== want) begin
        errors++; $display("FAIL rr_ack%0d: got %b want %b", n, bus.ack, want);
      end
      step();
      drop_fu(3'(order[n]));
      checks++;
      if (bus.cdb_packet !== std_cdb(3'(order[n]))) begin
        errors++; $display("FAIL rr_cdb%0d: got %h want %h", n, bus.cdb_packet,
                           std_cdb(3'(order[n])));
      end
    end
    #1;
    checks++;
    if (bus.ack !== 7'b0) begin
      errors++; $display("FAIL rr_ack_idle: got %b want %b", bus.ack, 7'b0);
    end
    step();
    checks++;
    if (bus.cdb_packet.valid !== 1'b0) begin
      errors++; $display("FAIL rr_cdb_idle: got %b want 0", bus.cdb_packet.valid);
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    bus.ex_cdb_packet = '0;
    set_std(3'd6);
    #1;
    checks++;
    if (bus.ack !== 7'b1000000) begin
      errors++; $display("FAIL wrap_ack6: got %b want %b", bus.ack, 7'b1000000);
    end
    step();
    drop_fu(3'd6);
    set_std(3'd6); set_std(3'd1);
    #1;
    checks++;
    if (bus.ack !== 7'b0000010) begin
      errors++; $display("FAIL wrap_ack1: got %b want %b", bus.ack, 7'b0000010);
    end
    step();
    drop_fu(3'd1);
    checks++;
    if (bus.cdb_packet !== std_cdb(3'd1)) begin
      errors++; $display("FAIL wrap_cdb1: got %h want %h", bus.cdb_packet, std_cdb(3'd1));
    end
    #1;
    checks++;
    if (bus.ack !== 7'b1000000) begin
      errors++; $display("FAIL wrap_ack6b: got %b want %b", bus.ack, 7'b1000000);
    end
    step();
    drop_fu(3'd6);
    checks++;
    if (bus.cdb_packet !== std_cdb(3'd6)) begin
      errors++; $display("FAIL wrap_cdb6: got %h want %h", bus.cdb_packet, std_cdb(3'd6));
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  want;
    cdb_packet_t exp;
    pulse_reset();
    bus.ex_cdb_packet = '0;
    for (int i = 0; i <= NUM_FU; i++) set_std(3'(i));
    set_fu(3'd4, 5'd4, 6'd0, 32'hA000_0004);
    for (int n = 1; n <= NUM_FU; n++) begin
      #1;
      want = 7'd1 << n;
      checks++;
      if (bus.ack !== want) begin
        errors++; $display("FAIL b2b_ack%0d: got %b want %b", n, bus.ack, want);
      end
      step();
      drop_fu(3'(n));
      exp = (n == 4) ? mk(5'd4, 6'd0, 32'hA000_0004) : std_cdb(3'(n));
      checks++;
      if (bus.cdb_packet !== exp) begin
        errors++; $display("FAIL b2b_cdb%0d: got %h want %h", n, bus.cdb_packet, exp);
      end
    end
    #1;
    checks++;
    if (bus.ack !== 7'b0) begin
      errors++; $display("FAIL b2b_fu0_only: got %b want %b", bus.ack, 7'b0);
    end
    bus.ex_cdb_packet = '0;
  endtask

  task automatic test_squash();
    pulse_reset();
    bus.ex_cdb_packet = '0;
    set_std(3'd2);
    step();
    drop_fu(3'd2);
    set_std(3'd4); set_std(3'd5);
    bus.squash = 1'b1;
    #1;
    checks++;
    if (bus.ack !== 7'b0) begin
      errors++; $display("FAIL squash_ack: got %b want %b", bus.ack, 7'b0);
    end
    checks++;
    if (bus.cdb_packet !== std_cdb(3'd2)) begin
      errors++; $display("FAIL squash_pending: got %h want %h", bus.cdb_packet, std_cdb(3'd2));
    end
    step();
    bus.squash = 1'b0;
    checks++;
    if (bus.cdb_packet !== cdb_packet_t'(0)) begin
      errors++; $display("FAIL squash_cdb: got %h want 0", bus.cdb_packet);
    end
    bus.ex_cdb_packet = '0;
    set_std(3'd1); set_std(3'd5);
    #1;
    checks++;
    if (bus.ack !== 7'b0000010) begin
      errors++; $display("FAIL squash_ptr: got %b want %b", bus.ack, 7'b0000010);
    end
    step();
    bus.ex_cdb_packet = '0;
    checks++;
    if (bus.cdb_packet !== std_cdb(3'd1)) begin
      errors++; $display("FAIL squash_after_cdb: got %h want %h", bus.cdb_packet, std_cdb(3'd1));
    end
  endtask

  task automatic test_fu0_vanish();
    pulse_reset();
    bus.ex_cdb_packet = '0;
    set_std(3'd0);
    #1;
    checks++;
    if (bus.ack !== 7'b0) begin
      errors++; $display("FAIL fu0_ack: got %b want %b", bus.ack, 7'b0);
    end
    step();
    checks++;
    if (bus.cdb_packet.valid !== 1'b0) begin
      errors++; $display("FAIL fu0_cdb: got %b want 0", bus.cdb_packet.valid);
    end
    set_std(3'd1); set_std(3'd2);
    #1;
    checks++;
    if (bus.ack !== 7'b0000010) begin
      errors++; $display("FAIL vanish_ack1: got %b want %b", bus.ack, 7'b0000010);
    end
    step();
    drop_fu(3'd1); drop_fu(3'd2);
    #1;
    checks++;
    if (bus.ack !== 7'b0) begin
      errors++; $display("FAIL vanish_ack_none: got %b want %b", bus.ack, 7'b0);
    end
    step();
    checks++;
    if (bus.cdb_packet !== cdb_packet_t'(0)) begin
      errors++; $display("FAIL vanish_cdb: got %h want 0", bus.cdb_packet);
    end
    set_std(3'd1); set_std(3'd2);
    #1;
    checks++;
    if (bus.ack !== 7'b0000100) begin
      errors++; $display("FAIL vanish_ptr: got %b want %b", bus.ack, 7'b0000100);
    end
    step();
    bus.ex_cdb_packet = '0;
    checks++;
    if (bus.cdb_packet !== std_cdb(3'd2)) begin
      errors++; $display("FAIL vanish_cdb2: got %h want %h", bus.cdb_packet, std_cdb(3'd2));
    end
  endtask

  task automatic test_reset_midstream();
    pulse_reset();
    bus.ex_cdb_packet = '0;
    set_std(3'd3);
    #1;
    checks++;
    if (bus.ack !== 7'b0001000) begin
      errors++; $display("FAIL mid_ack_pre: got %b want %b", bus.ack, 7'b0001000);
    end
    reset = 1'b0;
    bus.squash = 1'b1;
    #1;
    checks++;
    if (bus.ack !== 7'b0) begin
      errors++; $display("FAIL mid_ack_rst: got %b want %b", bus.ack, 7'b0);
    end
    step();
    checks++;
    if (bus.cdb_packet !== cdb_packet_t'(0)) begin
      errors++; $display("FAIL mid_cdb_rst: got %h want 0", bus.cdb_packet);
    end
    reset = 1'b1;
    bus.squash = 1'b0;
    #1;
    checks++;
    if (bus.ack !== 7'b0001000) begin
      errors++; $display("FAIL mid_ack_post: got %b want %b", bus.ack, 7'b0001000);
    end
    step();
    bus.ex_cdb_packet = '0;
    checks++;
    if (bus.cdb_packet !== std_cdb(3'd3)) begin
      errors++; $display("FAIL mid_cdb_post: got %h want %h", bus.cdb_packet, std_cdb(3'd3));
    end
  endtask

  initial begin
    bus.ex_cdb_packet = '0;
    bus.squash = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_squash();
    test_fu0_vanish();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-side counterpart of the execute stage. Each cycle it watches the finished-result outputs of all functional units and returns a one-hot `ack` to exactly one unit. It then registers that unit's result as the next common-data-bus broadcast to the RS, ROB and map table. Arbitration is round-robin over FUs 1..`NUM_FU`, so no unit starves. A ROB squash suppresses grants and invalidates the pending broadcast.

## Interface
- `NUM_FU`, default 6: number of functional units, indexed 1..`NUM_FU`. Index 0 exists in packet arrays but is never a requester.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clock`).
- `ex_cdb_packet`  in  EX_CDB_PACKET  per-FU results `fu_out_packets[0..NUM_FU]`. Fields used: `done`, `rob_tag`, `dest_tag`, `result`.
- `squash`  in  1  ROB flush; all in-flight FU results are dead.
- `cdb_ex_packet`  out  CDB_EX_PACKET  `ack[NUM_FU:0]`, combinational grant, at most one bit set.
- `cdb_packet`  out  CDB_PACKET  registered broadcast with fields `valid`, `rob_tag`, `dest_tag`, `value`.

## Operation
- Request vector: `req[i] = fu_out_packets[i].done` for i in 1..`NUM_FU`. `req[0]` is forced 0.
- Priority pointer `ptr` is registered, in range 1..`NUM_FU`, reset value 1.
- Search order: `ptr`, `ptr+1`, …, `NUM_FU`, 1, …, `ptr-1`. The first requester in that order wins.
- `ack[w] = 1` for the winner `w`; all other bits are 0. `ack = 0` when there is no request or when `squash = 1`.
- Pointer update on the edge where a grant occurs: `ptr <= w+1`, wrapping `NUM_FU+1 -> 1`.
  - No grant: `ptr` holds.
  - `squash`: `ptr <= 1`.
- Broadcast register, on every edge:
  - Grant: `cdb_packet <= {1, rob_tag[w], dest_tag[w], result[w]}`.
  - No grant: `cdb_packet.valid <= 0`; the other fields are don't-care but must be zeroed.
  - `squash`: whole `cdb_packet <= 0`. This also kills a broadcast that would otherwise issue this cycle.
- Stores and branches arbitrate like any other unit. A grant with `dest_tag = 0` still produces `valid = 1`; consumers ignore tag 0.
- An FU keeps `done` and its result stable until it sees `ack`, and drops `done` the cycle after. The arbiter holds no per-FU state beyond `ptr`.
- `done` falling without an ack (an FU cleared by mispredict logic) simply removes the request. Nothing is latched.

## Timing
- Reset (`reset = 0` at an edge) sets `ptr = 1` and `cdb_packet = 0`. `ack` is 0 combinationally whenever `squash = 1`, and also during reset.
- Grant latency: 0 cycles from `done` to `ack` (same cycle).
- Broadcast latency: 1 cycle from `ack` to `cdb_packet.valid`.
- Throughput: one broadcast per cycle. Back-to-back grants to different FUs are allowed in consecutive cycles.
- A unit granted in cycle t is lowest priority in cycle t+1. With all `NUM_FU` units requesting, each waits at most `NUM_FU-1` cycles.
- Simultaneous `squash` and `reset`: reset wins, and the result is identical either way.
- Reset asserted mid-stream: `cdb_packet` is 0 on the next cycle regardless of pending requests.

## Test plan
- Reset: hold `reset = 0` for 2 cycles with all `done = 1` -> `ack = 0`, `cdb_packet.valid = 0`. After release, the first grant goes to FU1.
- Single request: FU3 `done`, rob_tag 5, dest 12, result 0xDEADBEEF -> `ack[3]` the same cycle. Next cycle `cdb_packet = {1, 5, 12, 0xDEADBEEF}`.
- Round-robin: FU1, FU2 and FU5 hold `done` until acked, starting with `ptr = 1` -> grants FU1, FU2, FU5 in consecutive cycles, with three consecutive valid broadcasts.
- Wrap-around: after FU6 is granted (`ptr` wraps to 1), FU6 and FU1 request together -> FU1 is granted first, FU6 next cycle.
- Squash: FU4 and FU5 request with `squash = 1` -> `ack = 0` and `cdb_packet.valid = 0` next cycle. A valid broadcast pending from the prior grant is cleared, and `ptr = 1` afterwards.
- FU0 and a vanishing request: `fu_out_packets[0].done = 1` -> `ack[0]` is never set. FU2 drops `done` before being acked -> no broadcast for FU2 and `ptr` is unchanged.
